// File: rtl/cpu_multicycle_if.sv
// cpu_multicycle_if: shared instruction/data memory port with a req/ready handshake.
interface cpu_multicycle_if #(
  parameter int DW = 16
);
  logic req;
  logic we;
  logic ready;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  modport master(output req, we, addr, wdata, input rdata, ready);
  modport slave(input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multicycle core (FETCH/DECODE/EXEC/MEM/WB) on one stallable memory port.
// Defining CPU_HALT_EN turns op 111 into a HALT state that only reset leaves.
module cpu_multicycle #(
  parameter int DW = 16,
  parameter int NREG = 8,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  cpu_multicycle_if.master mem,
  output logic [DW-1:0] pc,
  output logic halted
);
`ifdef CPU_HALT_EN
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
`else
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
`endif
  state_t state, state_nx, idle_st;
  logic [15:0] ir;
  logic [DW-1:0] a, b, alu_out, mdr, alu_res, imm;
  logic [DW-1:0] rf [NREG];
  logic [2:0] op, rs, rt, rd, funct, wr_sel;
  logic rtype_ok;
  assign {op, rs, rt, rd} = ir[15:4];
  assign funct = ir[2:0];
  assign imm = {{(DW-7){ir[6]}}, ir[6:0]};
  assign rtype_ok = op == 3'b000 && funct <= 3'd4;
  assign wr_sel = op == 3'b000 ? rd : rt;
  assign alu_res = op != 3'b000 ? a + imm :
                   funct == 3'd0 ? a + b :
                   funct == 3'd1 ? a - b :
                   funct == 3'd2 ? a & b :
                   funct == 3'd3 ? a | b : DW'($signed(a) < $signed(b));
`ifdef CPU_HALT_EN
  assign idle_st = op == 3'b111 ? HALT : FETCH;
  assign halted = state == HALT;
`else
  assign idle_st = FETCH;
  assign halted = 1'b0;
`endif
  // Bus outputs are decoded from state and forced idle while reset is held.
  assign mem.req = reset && (state == FETCH || state == MEM);
  assign mem.we = reset && state == MEM && op == 3'b010;
  assign mem.addr = !reset ? '0 : state == FETCH ? pc : state == MEM ? alu_out : '0;
  assign mem.wdata = reset && state == MEM ? b : '0;
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = mem.ready ? DECODE : FETCH;
      DECODE:  state_nx = EXEC;
      EXEC:    state_nx = (rtype_ok || op == 3'b100) ? WB : (op == 3'b001 || op == 3'b010) ? MEM : idle_st;
      MEM:     state_nx = !mem.ready ? MEM : op == 3'b001 ? WB : FETCH;
      WB:      state_nx = FETCH;
      default: state_nx = state;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH && mem.ready) begin
        ir <= mem.rdata[15:0];
        pc <= pc + DW'(1);
      end
      if (state == DECODE) begin
        a <= rf[rs];
        b <= rf[rt];
      end
      if (state == EXEC) begin
        alu_out <= alu_res;
        if (op == 3'b011 && a == b) pc <= pc + imm;
        if (op == 3'b101) pc <= DW'(ir[12:0]);
      end
      if (state == MEM && mem.ready) mdr <= mem.rdata;
      if (state == WB && wr_sel != 3'd0) rf[wr_sel] <= op == 3'b001 ? mdr : alu_out;
    end
  end
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed programs against a behavioural memory; registers are observed through stores.
module tb_cpu_multicycle;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] pc;
  logic halted;
  logic [15:0] ram [256];
  logic [15:0] rd_log [64];
  int rd_cnt = 0;
  logic wseen = 1'b0;
  logic [15:0] w_addr = '0, w_data = '0;
  logic clr = 1'b0, ld_en = 1'b0;
  logic [7:0] ld_a = '0;
  logic [15:0] ld_d = '0;
  int mode = 0, cyc = 0, checks = 0, failures = 0;
  logic stall_chk = 1'b0, p_req = 1'b0, p_rdy = 1'b0;
  logic [15:0] p_addr = '0;

  cpu_multicycle_if #(.DW(16)) bus ();
  cpu_multicycle #(.DW(16), .NREG(8), .RESET_PC(16'd0)) dut (.clk(clk), .reset(reset), .mem(bus), .pc(pc), .halted(halted));

  always #5 clk = ~clk;
  assign bus.rdata = ram[bus.addr[7:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      rd_cnt <= 0;
      wseen <= 1'b0;
    end else if (ld_en) ram[ld_a] <= ld_d;
    else if (reset && bus.req && bus.ready) begin
      if (bus.we) begin
        ram[bus.addr[7:0]] <= bus.wdata;
        if (!wseen) begin
          w_addr <= bus.addr;
          w_data <= bus.wdata;
          wseen <= 1'b1;
        end
      end else if (rd_cnt < 64) begin
        rd_log[rd_cnt] <= bus.addr;
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && stall_chk && p_req && !p_rdy) begin
      chk("stall_req", bus.req, 1);
      chk("stall_addr", bus.addr, p_addr);
    end
    p_req = bus.req;
    p_addr = bus.addr;
    cyc = cyc + 1;
    bus.ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : !(bus.req && bus.addr == 16'd10);
    p_rdy = bus.ready;
  end

  function automatic logic [15:0] i_ty(input logic [2:0] op, input logic [2:0] rt, input logic [2:0] rs, input int imm);
    return {op, rs, rt, 7'(imm)};
  endfunction
  function automatic logic [15:0] r_ty(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
    return {3'b000, rs, rt, rd, 1'b0, f};
  endfunction
  function automatic logic [15:0] jmp(input int t);
    return {3'b101, 13'(t)};
  endfunction

  task automatic boot();
    reset = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask
  task automatic ld(input int a, input logic [15:0] d);
    ld_en = 1'b1;
    ld_a = 8'(a);
    ld_d = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask
  task automatic start(input int m);
    mode = m;
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic prog_sum();
    ld(0, i_ty(3'd4, 1, 0, 5));
    ld(1, i_ty(3'd4, 2, 0, -3));
    ld(2, r_ty(3'd0, 3, 1, 2));
    ld(3, i_ty(3'd2, 3, 0, 40));
    ld(4, i_ty(3'd2, 1, 0, 41));
    ld(5, jmp(5));
  endtask

  initial begin
    int n;
    boot();
    chk("rst_pc", pc, 0);
    chk("rst_req", bus.req, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_halted", halted, 0);
    prog_sum();
    start(0);
    run(12);
    chk("sum_pc12", pc, 3);
    chk("sum_req12", bus.req, 1);
    chk("sum_addr12", bus.addr, 3);
    run(40);
    chk("sum_r3", ram[40], 2);
    chk("sum_r1", ram[41], 5);

    boot();
    prog_sum();
    stall_chk = 1'b1;
    start(1);
    run(120);
    stall_chk = 1'b0;
    chk("stall_r3", ram[40], 2);
    chk("stall_r1", ram[41], 5);

    boot();
    ld(0, i_ty(3'd4, 1, 0, 7));
    ld(1, i_ty(3'd2, 1, 0, 10));
    ld(2, i_ty(3'd1, 4, 0, 10));
    ld(3, i_ty(3'd2, 4, 0, 11));
    ld(4, jmp(4));
    start(0);
    run(40);
    chk("sw_seen", wseen, 1);
    chk("sw_addr", w_addr, 10);
    chk("sw_data", w_data, 7);
    chk("lw_r4", ram[11], 7);

    boot();
    ld(0, i_ty(3'd4, 1, 0, 3));
    ld(1, i_ty(3'd4, 2, 0, 3));
    ld(2, jmp(4));
    ld(3, jmp(3));
    ld(4, i_ty(3'd3, 2, 1, -2));
    start(0);
    run(30);
    chk("beq_t_at", rd_log[3], 4);
    chk("beq_t_next", rd_log[4], 3);

    boot();
    ld(0, i_ty(3'd4, 1, 0, 3));
    ld(1, i_ty(3'd4, 2, 0, 4));
    ld(2, jmp(4));
    ld(3, jmp(3));
    ld(4, i_ty(3'd3, 2, 1, -2));
    ld(5, jmp(32));
    ld(32, jmp(32));
    start(0);
    run(30);
    chk("beq_nt_next", rd_log[4], 5);
    chk("j_next", rd_log[5], 32);

    boot();
    ld(0, i_ty(3'd4, 0, 0, 9));
    ld(1, i_ty(3'd4, 1, 0, 1));
    ld(2, r_ty(3'd1, 6, 0, 1));
    ld(3, r_ty(3'd1, 0, 0, 1));
    ld(4, i_ty(3'd2, 0, 0, 50));
    ld(5, i_ty(3'd2, 6, 0, 51));
    ld(6, i_ty(3'd1, 5, 0, 56));
    ld(7, i_ty(3'd4, 5, 5, 1));
    ld(8, i_ty(3'd2, 5, 0, 52));
    ld(9, r_ty(3'd4, 7, 5, 1));
    ld(10, i_ty(3'd2, 7, 0, 53));
    ld(11, r_ty(3'd4, 7, 1, 5));
    ld(12, i_ty(3'd2, 7, 0, 54));
    ld(13, r_ty(3'd2, 2, 6, 5));
    ld(14, r_ty(3'd3, 3, 1, 5));
    ld(15, i_ty(3'd2, 2, 0, 55));
    ld(16, i_ty(3'd2, 3, 0, 57));
    ld(17, jmp(17));
    ld(56, 16'h7FFF);
    start(0);
    run(100);
    chk("r0_zero", ram[50], 0);
    chk("sub_neg1", ram[51], 16'hFFFF);
    chk("addi_wrap", ram[52], 16'h8000);
    chk("slt_true", ram[53], 1);
    chk("slt_false", ram[54], 0);
    chk("and_res", ram[55], 16'h8000);
    chk("or_res", ram[57], 16'h8001);

    boot();
    ld(0, i_ty(3'd4, 1, 0, 5));
    ld(1, i_ty(3'd2, 1, 0, 10));
    start(2);
    run(12);
    chk("mem_wait_req", bus.req, 1);
    chk("mem_wait_we", bus.we, 1);
    chk("mem_wait_addr", bus.addr, 10);
    chk("mem_wait_wdata", bus.wdata, 5);
    reset = 1'b0;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_req", bus.req, 0);
    chk("arst_we", bus.we, 0);
    chk("arst_addr", bus.addr, 0);
    boot();
    ld(0, i_ty(3'd2, 1, 0, 20));
    ld(1, jmp(1));
    ld(20, 16'hAAAA);
    start(0);
    run(20);
    chk("arst_r1_cleared", ram[20], 0);

    boot();
    ld(0, i_ty(3'd4, 1, 0, 1));
    ld(1, 16'hE000);
    ld(2, i_ty(3'd2, 1, 0, 30));
    ld(3, jmp(3));
    start(0);
    run(12);
`ifdef CPU_HALT_EN
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, 2);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      run(1);
      if (bus.req) n++;
    end
    chk("halt_noreq", n, 0);
    chk("halt_pc_frozen", pc, 2);
    chk("halt_no_store", ram[30], 0);
`else
    n = 0;
    run(20);
    chk("op7_no_halt", halted, n);
    chk("op7_nop_store", ram[30], 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
